// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared types and constants for the QSPI shift engine
package qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HI,
        LO,
        HOLD,
        GAP
    } state_t;

    localparam logic       LANE_SINGLE = 1'b0;
    localparam logic       LANE_QUAD   = 1'b1;
    localparam logic [3:0] OE_SINGLE   = 4'b0001;

    // Zero requests the mode maximum; anything larger is clamped to it.
    function automatic logic [6:0] clamp_cycles(input logic [5:0] req, input logic [6:0] max_cyc);
        if (req == 6'd0 || {1'b0, req} > max_cyc) begin
            return max_cyc;
        end
        return {1'b0, req};
    endfunction

endpackage

// File: rtl/qspi_half_tick.sv
// rtl/qspi_half_tick.sv - SCK half-period counter, flags the last cycle of each phase
module qspi_half_tick (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] prescal,
    input  logic       restart,
    output logic       phase_end
);

    logic [7:0] cnt;
    logic [7:0] period;

    assign period    = (prescal == 8'd0) ? 8'd1 : prescal;
    assign phase_end = (cnt == period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd1;
        end else if (restart) begin
            cnt <= 8'd1;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/qspi_shift_engine.sv
// rtl/qspi_shift_engine.sv - single/quad lane SPI shift engine, SCK mode 0
module qspi_shift_engine
    import qspi_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          ahb_clk_i,
    input  logic          ahb_rst_i,
    input  logic [7:0]    qspi_prescal_i,
    input  logic          start_i,
    input  logic          quad_i,
    input  logic          dir_i,
    input  logic [5:0]    xfer_cyc_i,
    input  logic [DW-1:0] tx_data_i,
    output logic [DW-1:0] rx_data_o,
    output logic          done_o,
    output logic          qspi_busy_o,
    output logic          qspi_sck_o,
    output logic          qspi_cs_n_o,
    output logic [3:0]    qspi_io_o,
    output logic [3:0]    qspi_io_oe_o,
    input  logic [3:0]    qspi_io_i
);

    state_t        state;
    state_t        state_next;
    logic [7:0]    prescal_q;
    logic          quad_q;
    logic          dir_q;
    logic [6:0]    remaining;
    logic [DW-1:0] tx_sh;
    logic [DW-1:0] rx_sh;
    logic [DW-1:0] tx_shifted;
    logic [DW-1:0] rx_sampled;
    logic [6:0]    cyc_max;
    logic          phase_end;
    logic          restart;

    function automatic logic [3:0] lane_io(input logic q, input logic d, input logic [DW-1:0] w);
        if (q == LANE_QUAD) begin
            return d ? 4'h0 : w[DW-1 -: 4];
        end
        return {3'b000, w[DW-1]};
    endfunction

    function automatic logic [3:0] lane_oe(input logic q, input logic d);
        if (q == LANE_QUAD) begin
            return d ? 4'h0 : 4'hF;
        end
        return OE_SINGLE;
    endfunction

    assign cyc_max    = (quad_i == LANE_QUAD) ? 7'(DW / 4) : 7'(DW);
    assign tx_shifted = (quad_q == LANE_QUAD) ? {tx_sh[DW-5:0], 4'h0} : {tx_sh[DW-2:0], 1'b0};
    assign rx_sampled = (quad_q == LANE_QUAD) ? {rx_sh[DW-5:0], qspi_io_i}
                                              : {rx_sh[DW-2:0], qspi_io_i[1]};

    // Holding the counter at 1 while idle makes the first SETUP cycle count 1.
    assign restart = (state_next != state) || (state == IDLE);

    qspi_half_tick u_half_tick (
        .clk       (ahb_clk_i),
        .rst_n     (ahb_rst_i),
        .prescal   (prescal_q),
        .restart   (restart),
        .phase_end (phase_end)
    );

    always_ff @(posedge ahb_clk_i or negedge ahb_rst_i) begin
        if (!ahb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i)   state_next = SETUP;
            SETUP:   if (phase_end) state_next = HI;
            HI:      if (phase_end) state_next = (remaining == 7'd0) ? HOLD : LO;
            LO:      if (phase_end) state_next = HI;
            HOLD:    if (phase_end) state_next = GAP;
            GAP:     if (phase_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ahb_clk_i or negedge ahb_rst_i) begin
        if (!ahb_rst_i) begin
            prescal_q    <= 8'd1;
            quad_q       <= LANE_SINGLE;
            dir_q        <= 1'b0;
            remaining    <= 7'd0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            rx_data_o    <= '0;
            done_o       <= 1'b0;
            qspi_busy_o  <= 1'b0;
            qspi_sck_o   <= 1'b0;
            qspi_cs_n_o  <= 1'b1;
            qspi_io_o    <= 4'h0;
            qspi_io_oe_o <= 4'h0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        prescal_q    <= qspi_prescal_i;
                        quad_q       <= quad_i;
                        dir_q        <= dir_i;
                        remaining    <= clamp_cycles(xfer_cyc_i, cyc_max);
                        tx_sh        <= tx_data_i;
                        rx_sh        <= '0;
                        qspi_cs_n_o  <= 1'b0;
                        qspi_busy_o  <= 1'b1;
                        qspi_io_o    <= lane_io(quad_i, dir_i, tx_data_i);
                        qspi_io_oe_o <= lane_oe(quad_i, dir_i);
                    end
                end
                SETUP, LO: begin
                    if (phase_end) begin
                        qspi_sck_o <= 1'b1;
                        rx_sh      <= rx_sampled;
                        remaining  <= remaining - 7'd1;
                    end
                end
                HI: begin
                    if (phase_end) begin
                        qspi_sck_o <= 1'b0;
                        if (remaining != 7'd0) begin
                            tx_sh     <= tx_shifted;
                            qspi_io_o <= lane_io(quad_q, dir_q, tx_shifted);
                        end
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        qspi_cs_n_o  <= 1'b1;
                        qspi_io_oe_o <= 4'h0;
                        qspi_io_o    <= 4'h0;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        qspi_busy_o <= 1'b0;
                        done_o      <= 1'b1;
                        rx_data_o   <= rx_sh;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_shift_engine.sv
// tb/tb_qspi_shift_engine.sv - directed self-checking bench for qspi_shift_engine
module tb_qspi_shift_engine;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    prescal;
    logic          start;
    logic          quad;
    logic          dir;
    logic [5:0]    cyc;
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
    logic          done;
    logic          busy;
    logic          sck;
    logic          cs_n;
    logic [3:0]    io_o;
    logic [3:0]    oe;
    logic [3:0]    io_i;

    int n_cmp = 0;
    int n_bad = 0;

    int          busy_n, done_n, rises, oe_bad;
    logic [63:0] cap1, cap4;

    always #5 clk = ~clk;

    qspi_shift_engine #(.DW(DW)) dut (
        .ahb_clk_i      (clk),
        .ahb_rst_i      (rst_n),
        .qspi_prescal_i (prescal),
        .start_i        (start),
        .quad_i         (quad),
        .dir_i          (dir),
        .xfer_cyc_i     (cyc),
        .tx_data_i      (tx),
        .rx_data_o      (rx),
        .done_o         (done),
        .qspi_busy_o    (busy),
        .qspi_sck_o     (sck),
        .qspi_cs_n_o    (cs_n),
        .qspi_io_o      (io_o),
        .qspi_io_oe_o   (oe),
        .qspi_io_i      (io_i)
    );

    function automatic logic [3:0] slave_val(input logic q, input logic [31:0] sw, input int eff_c, input int k);
        if (k >= eff_c) return 4'h0;
        if (q) return sw[4*(eff_c-1-k) +: 4];
        return {2'b00, sw[eff_c-1-k], 1'b0};
    endfunction

    task automatic do_xfer(input logic [7:0] pre, input logic q, input logic d, input logic [5:0] c,
                           input logic [31:0] txw, input logic [31:0] sw, input int eff_c,
                           input logic [3:0] exp_oe, input bit perturb);
        logic prev_sck, prev_cs;
        int   k, post;
        bit   seen;
        busy_n = 0; done_n = 0; rises = 0; oe_bad = 0; cap1 = '0; cap4 = '0;
        k = 0; post = 0; seen = 0;
        @(negedge clk);
        prescal = pre; quad = q; dir = d; cyc = c; tx = txw; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prev_sck = 1'b0; prev_cs = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (busy) busy_n++;
            if (done) done_n++;
            if (!cs_n && oe !== exp_oe) oe_bad++;
            if (sck && !prev_sck) begin
                rises++;
                cap1 = {cap1[62:0], io_o[0]};
                cap4 = {cap4[59:0], io_o};
            end
            if (!cs_n && prev_cs) begin
                k = 0;
                io_i = slave_val(q, sw, eff_c, k);
            end else if (!sck && prev_sck && !cs_n) begin
                k++;
                io_i = slave_val(q, sw, eff_c, k);
            end
            if (perturb && i == 5) begin
                start = 1'b1; prescal = 8'd7; tx = '1; cyc = 6'd1; quad = ~q;
            end
            if (perturb && i == 6) start = 1'b0;
            prev_sck = sck; prev_cs = cs_n;
            if (done) seen = 1;
            if (seen) begin
                if (post == 4) break;
                post++;
            end
            @(negedge clk);
        end
        io_i = 4'h0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_cmp++; if (cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        n_cmp++; if (sck !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", sck); end
        n_cmp++; if (io_o !== 4'h0 || oe !== 4'h0) begin n_bad++; $display("FAIL reset_io: got io=%h oe=%h want 0/0", io_o, oe); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done: got %b/%b want 0/0", busy, done); end
        n_cmp++; if (rx !== 32'h0) begin n_bad++; $display("FAIL reset_rx: got %h want 0", rx); end
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || cs_n !== 1'b1) begin n_bad++; $display("FAIL idle_after_reset: got busy=%b cs_n=%b want 0/1", busy, cs_n); end
    endtask

    task automatic test_single();
        do_xfer(8'd2, 1'b0, 1'b0, 6'd8, 32'hA500_0000, 32'h3C, 8, 4'b0001, 0);
        n_cmp++; if (cap1[7:0] !== 8'hA5) begin n_bad++; $display("FAIL single_tx_bits: got %h want a5", cap1[7:0]); end
        n_cmp++; if (rx !== 32'h0000_003C) begin n_bad++; $display("FAIL single_rx: got %h want 0000003c", rx); end
        n_cmp++; if (busy_n !== 36) begin n_bad++; $display("FAIL single_busy: got %0d want 36", busy_n); end
        n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL single_done: got %0d want 1", done_n); end
        n_cmp++; if (rises !== 8) begin n_bad++; $display("FAIL single_rises: got %0d want 8", rises); end
        n_cmp++; if (oe_bad !== 0) begin n_bad++; $display("FAIL single_oe: got %0d bad cycles want 0", oe_bad); end
    endtask

    task automatic test_quad_tx();
        do_xfer(8'd0, 1'b1, 1'b0, 6'd8, 32'h1234_5678, 32'h0, 8, 4'hF, 0);
        n_cmp++; if (cap4[31:0] !== 32'h1234_5678) begin n_bad++; $display("FAIL quad_tx_nibbles: got %h want 12345678", cap4[31:0]); end
        n_cmp++; if (oe_bad !== 0) begin n_bad++; $display("FAIL quad_tx_oe: got %0d bad cycles want 0", oe_bad); end
        n_cmp++; if (busy_n !== 18) begin n_bad++; $display("FAIL quad_tx_busy: got %0d want 18", busy_n); end
        n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL quad_tx_done: got %0d want 1", done_n); end
    endtask

    task automatic test_quad_rx();
        do_xfer(8'd3, 1'b1, 1'b1, 6'd2, 32'hFFFF_FFFF, 32'hE7, 2, 4'h0, 0);
        n_cmp++; if (rx !== 32'h0000_00E7) begin n_bad++; $display("FAIL quad_rx_data: got %h want 000000e7", rx); end
        n_cmp++; if (oe_bad !== 0) begin n_bad++; $display("FAIL quad_rx_oe: got %0d bad cycles want 0", oe_bad); end
        n_cmp++; if (cap4[7:0] !== 8'h00) begin n_bad++; $display("FAIL quad_rx_io_quiet: got %h want 00", cap4[7:0]); end
        n_cmp++; if (busy_n !== 18) begin n_bad++; $display("FAIL quad_rx_busy: got %0d want 18", busy_n); end
        repeat (5) @(negedge clk);
        n_cmp++; if (rx !== 32'h0000_00E7) begin n_bad++; $display("FAIL rx_hold: got %h want 000000e7", rx); end
    endtask

    task automatic test_clamps();
        do_xfer(8'd1, 1'b0, 1'b0, 6'd0, 32'hDEAD_BEEF, 32'h1234_5678, 32, 4'b0001, 0);
        n_cmp++; if (rises !== 32) begin n_bad++; $display("FAIL clamp_single_rises: got %0d want 32", rises); end
        n_cmp++; if (busy_n !== 66) begin n_bad++; $display("FAIL clamp_single_busy: got %0d want 66", busy_n); end
        n_cmp++; if (cap1[31:0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL clamp_single_tx: got %h want deadbeef", cap1[31:0]); end
        n_cmp++; if (rx !== 32'h1234_5678) begin n_bad++; $display("FAIL clamp_single_rx: got %h want 12345678", rx); end
        do_xfer(8'd1, 1'b1, 1'b0, 6'd20, 32'hCAFE_F00D, 32'h0, 8, 4'hF, 0);
        n_cmp++; if (rises !== 8) begin n_bad++; $display("FAIL clamp_quad_rises: got %0d want 8", rises); end
        n_cmp++; if (busy_n !== 18) begin n_bad++; $display("FAIL clamp_quad_busy: got %0d want 18", busy_n); end
        n_cmp++; if (cap4[31:0] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL clamp_quad_tx: got %h want cafef00d", cap4[31:0]); end
    endtask

    task automatic test_back_to_back();
        do_xfer(8'd2, 1'b0, 1'b0, 6'd4, 32'h9000_0000, 32'hA, 4, 4'b0001, 1);
        n_cmp++; if (busy_n !== 20) begin n_bad++; $display("FAIL perturb_busy: got %0d want 20", busy_n); end
        n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL perturb_done: got %0d want 1", done_n); end
        n_cmp++; if (rises !== 4) begin n_bad++; $display("FAIL perturb_rises: got %0d want 4", rises); end
        n_cmp++; if (cap1[3:0] !== 4'b1001) begin n_bad++; $display("FAIL perturb_tx: got %b want 1001", cap1[3:0]); end
        n_cmp++; if (rx !== 32'h0000_000A) begin n_bad++; $display("FAIL perturb_rx: got %h want 0000000a", rx); end
    endtask

    task automatic test_reset_mid();
        bit found;
        int dn;
        found = 0; dn = 0;
        @(negedge clk);
        prescal = 8'd2; quad = 1'b0; dir = 1'b0; cyc = 6'd8; tx = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sck) begin found = 1; break; end
            @(negedge clk);
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL rstmid_reach_hi: got no sck high want sck high"); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (cs_n !== 1'b1 || sck !== 1'b0) begin n_bad++; $display("FAIL rstmid_cs_sck: got %b/%b want 1/0", cs_n, sck); end
        n_cmp++; if (oe !== 4'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_oe_busy: got %h/%b want 0/0", oe, busy); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d want 0", dn); end
        do_xfer(8'd1, 1'b0, 1'b0, 6'd2, 32'h4000_0000, 32'h2, 2, 4'b0001, 0);
        n_cmp++; if (busy_n !== 6 || done_n !== 1) begin n_bad++; $display("FAIL rstmid_recover: got busy=%0d done=%0d want 6/1", busy_n, done_n); end
        n_cmp++; if (cap1[1:0] !== 2'b01 || rx !== 32'h2) begin n_bad++; $display("FAIL rstmid_data: got tx=%b rx=%h want 01/00000002", cap1[1:0], rx); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; prescal = 8'd0; start = 1'b0; quad = 1'b0; dir = 1'b0;
        cyc = 6'd0; tx = '0; io_i = 4'h0;
        test_reset();
        test_single();
        test_quad_tx();
        test_quad_rx();
        test_clamps();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qspi_shift_engine.md
Name: qspi_shift_engine

Overview:
Serial shift engine for the Quad-SPI controller. It takes one transfer command from the AHB register block, drives CS_n, SCK and the IO lanes in single or quad mode, and returns the received word. It runs on the AHB clock and generates SCK as a registered output paced by the programmed prescaler. Its qspi_busy_o feeds the busy input of the prescaler/clock-divider stage, which freezes the prescaler during a transfer.

Parameters:
DW, 32, transfer data width in bits; must be a multiple of 4.

Ports:
ahb_clk_i  input  1  AHB clock; the only clock.
ahb_rst_i  input  1  asynchronous, active-low reset.
qspi_prescal_i  input  8  SCK half-period in ahb_clk_i cycles; 0 is treated as 1.
start_i  input  1  single-cycle transfer request; honoured only in IDLE.
quad_i  input  1  0 = single lane, 1 = quad lanes.
dir_i  input  1  quad mode only: 0 = transmit, 1 = receive.
xfer_cyc_i  input  6  number of SCK cycles. Valid ranges: 1..DW in single mode, 1..DW/4 in quad mode.
tx_data_i  input  DW  transmit word, sent MSB first.
rx_data_o  output  DW  received word, right-aligned.
done_o  output  1  one-cycle pulse when a transfer completes.
qspi_busy_o  output  1  transfer in progress.
qspi_sck_o  output  1  serial clock; mode 0, idles low.
qspi_cs_n_o  output  1  chip select, active low.
qspi_io_o  output  4  IO lane drive values.
qspi_io_oe_o  output  4  IO lane output enables.
qspi_io_i  input  4  IO lane sampled inputs.

Behaviour:
- Reset values: qspi_cs_n_o=1, qspi_sck_o=0, qspi_io_o=0, qspi_io_oe_o=0, qspi_busy_o=0, done_o=0, rx_data_o=0, state=IDLE.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous). No done_o is generated.
- Command latch: start_i in IDLE latches P=max(qspi_prescal_i,1), quad_i, dir_i, C, tx_data_i.
  - C rule: xfer_cyc_i of 0 maps to the mode maximum (DW single, DW/4 quad). Values above the maximum clamp to the maximum.
  - start_i outside IDLE is ignored.
  - Input changes during a transfer have no effect.
- Half-period counter: counts 1..P and restarts at each state change. "Phase end" means count==P.
- States:
  - IDLE: busy=0. On start_i, the next cycle enters SETUP with cs_n=0, busy=1, and the first bits driven.
  - SETUP (P cycles): SCK low, data stable. On phase end: SCK rises, io_i is sampled, remaining count decrements, go to HI.
  - HI (P cycles): on phase end, if remaining==0 then SCK falls and go to HOLD; otherwise SCK falls, tx shifts, and go to LO.
  - LO (P cycles): on phase end, SCK rises, io_i is sampled, go to HI.
  - HOLD (P cycles): SCK low, cs_n still 0. On phase end: cs_n=1, oe=0, go to GAP.
  - GAP (P cycles): cs_n=1, which guarantees minimum deselect time. On phase end: go to IDLE with busy=0 and done_o=1 for exactly one cycle. rx_data_o is updated in the same cycle.
- Sampling occurs on the same ahb_clk_i edge that registers SCK 0->1.
- Total busy time is exactly P*(2C+2) cycles, starting the cycle after start_i.
- Single mode:
  - Transmit on io[0] = tx[DW-1] with oe=4'b0001.
  - Receive from io_i[1]; rx shifts {rx[DW-2:0], io_i[1]}.
  - Transmit and receive happen simultaneously.
- Quad mode, transmit: io = tx[DW-1:DW-4], oe=4'hF, shift by 4 per cycle.
- Quad mode, receive: oe=0, io_o=0; rx shifts {rx[DW-5:0], io_i} per rising edge.
- rx_data_o holds its value between transfers. The shift register clears at start.

Decomposition:
- Package qspi_pkg holds:
  - the state enum (IDLE, SETUP, HI, LO, HOLD, GAP);
  - lane constants (LANE_SINGLE=0, LANE_QUAD=1);
  - the single-mode oe constant OE_SINGLE=4'b0001.
- One sub-module, qspi_half_tick: an 8-bit half-period counter with a restart input and a phase_end output, computing P=max(prescal,1). The FSM and shifters stay in the top module.

Test Plan:
- Single tx/rx, P=2, C=8, tx=0xA5000000, slave returns 0x3C on io[1]:
  - io[0] shows 1,0,1,0,0,1,0,1;
  - rx_data_o=0x0000003C;
  - busy high exactly 36 cycles;
  - one done_o pulse.
- Quad transmit, prescal=0 (P=1), C=8, tx=0x12345678:
  - io_o nibbles 1..8, one per SCK period;
  - oe=4'hF while cs_n=0;
  - busy 18 cycles.
- Quad receive, P=3, C=2, slave drives 0xE then 0x7: rx_data_o=0x000000E7, oe stays 0, busy 18 cycles.
- Clamps:
  - xfer_cyc_i=0 in single mode gives 32 SCK rising edges;
  - xfer_cyc_i=20 in quad mode clamps to 8 SCK cycles.
- start_i pulsed again mid-transfer, and qspi_prescal_i changed mid-transfer: the transfer is unaffected, with a single done_o.
- ahb_rst_i low in HI state: cs_n=1, sck=0, oe=0, busy=0 immediately; no done_o; a new start after reset completes normally.
